// File: rtl/antirebote_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package antirebote_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } antirebote_state_t;

    // Width of a counter that can hold the largest of the three limits.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/antirebote_canal.sv
// One debounce channel: 2-flop synchronizer, 4-state FSM and counters.
// Long-press timer is built only when ANTIREBOTE_LONG_PRESS_EN is defined.
module antirebote_canal
    import antirebote_pkg::*;
#(
    parameter int unsigned PRESS_CNT   = 50000,
    parameter int unsigned RELEASE_CNT = 501,
    parameter int unsigned LONG_CNT    = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic boton_in,
    output logic boton_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned CW = cnt_width(PRESS_CNT, RELEASE_CNT, LONG_CNT);
    localparam logic [CW-1:0] PRESS_LIM = CW'(PRESS_CNT);
    localparam logic [CW-1:0] REL_LIM   = CW'(RELEASE_CNT);

    logic              sync_1, sync_s;
    antirebote_state_t state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              press_nx, release_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1        <= 1'b1;
            sync_s        <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_1        <= boton_in;
            sync_s        <= sync_1;
            state         <= state_nx;
            cnt           <= cnt_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
        end
    end

    // A limit of 1 is already met on entry to a wait state, so that state
    // still lasts one cycle but exits regardless of the next sample.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        case (state)
            IDLE: begin
                if (!sync_s) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = CW'(1);
                end else begin
                    cnt_nx = '0;
                end
            end
            PRESS_WAIT: begin
                if (cnt >= PRESS_LIM || (!sync_s && (cnt + CW'(1)) >= PRESS_LIM)) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                    press_nx = 1'b1;
                end else if (sync_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HELD: begin
                if (sync_s) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = CW'(1);
                end else begin
                    cnt_nx = '0;
                end
            end
            RELEASE_WAIT: begin
                if (cnt >= REL_LIM || (sync_s && (cnt + CW'(1)) >= REL_LIM)) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    release_nx = 1'b1;
                end else if (!sync_s) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign boton_out = (state == HELD) || (state == RELEASE_WAIT);

`ifdef ANTIREBOTE_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CNT);

    logic [CW-1:0] long_cnt, long_cnt_nx;
    logic          long_nx;

    // Timer survives release glitches; it restarts only on a new press.
    always_comb begin
        long_cnt_nx = long_cnt;
        long_nx     = 1'b0;
        if (press_nx) begin
            long_cnt_nx = '0;
        end else if (state == HELD && !sync_s && long_cnt != LONG_LIM) begin
            long_cnt_nx = long_cnt + CW'(1);
            long_nx     = ((long_cnt + CW'(1)) == LONG_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_cnt   <= long_cnt_nx;
            long_pulse <= long_nx;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/antirebote_multicanal.sv
// N_CH independent button debouncers with press/release/long-press pulses.
// Long-press detection is enabled by defining ANTIREBOTE_LONG_PRESS_EN.
module antirebote_multicanal
    import antirebote_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned PRESS_CNT   = 50000,
    parameter int unsigned RELEASE_CNT = 501,
    parameter int unsigned LONG_CNT    = 50000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] boton_in,
    output logic [N_CH-1:0] boton_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        antirebote_canal #(
            .PRESS_CNT  (PRESS_CNT),
            .RELEASE_CNT(RELEASE_CNT),
            .LONG_CNT   (LONG_CNT)
        ) u_canal (
            .clk          (clk),
            .rst_n        (rst_n),
            .boton_in     (boton_in[i]),
            .boton_out    (boton_out[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_antirebote_multicanal.sv
// Directed table-driven bench for antirebote_multicanal (2 channels, 8/4/32).
module tb_antirebote_multicanal;

`ifdef ANTIREBOTE_LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] boton_in;
    logic [1:0] boton_out, press_pulse, release_pulse, long_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_p, cnt_r, cnt_l;

    typedef struct {
        logic       rst;
        logic [1:0] b;
        int         cyc;
        logic [1:0] out, prs, rel, lng;
        int         np, nr, nl;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    antirebote_multicanal #(
        .N_CH       (2),
        .PRESS_CNT  (8),
        .RELEASE_CNT(4),
        .LONG_CNT   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .boton_in     (boton_in),
        .boton_out    (boton_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    task automatic tick(input logic r, input logic [1:0] b);
        rst_n    = r;
        boton_in = b;
        @(posedge clk);
        #1;
        cnt_p += $countones(press_pulse);
        cnt_r += $countones(release_pulse);
        cnt_l += $countones(long_pulse);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] b, input int cyc,
                       input logic [1:0] out, input logic [1:0] prs,
                       input logic [1:0] rel, input logic [1:0] lng,
                       input int np, input int nr, input int nl);
        vec_t v;
        v.rst = r; v.b = b; v.cyc = cyc;
        v.out = out; v.prs = prs; v.rel = rel; v.lng = lng;
        v.np = np; v.nr = nr; v.nl = nl;
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0] lng1;
        int         nl1, lat;
        bit         found;
        lng1 = LP ? 2'b10 : 2'b00;
        nl1  = LP ? 1 : 0;

        // reset state and settle
        add(0, 2'b11, 2, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        // ch0 press: accepted on 10th cycle, one-cycle pulse, then clean release
        add(1, 2'b10, 9, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        add(1, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 5, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 0);
        add(1, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        // 7-cycle lows separated by 1-cycle highs are rejected
        for (int i = 0; i < 3; i++) begin
            add(1, 2'b10, 7, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
            add(1, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        end
        add(1, 2'b11, 4, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        // release glitch of 3 highs ignored, clean release after 6 cycles
        add(1, 2'b10, 10, 2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        add(1, 2'b10, 2, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 3, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b10, 3, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 5, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 0);
        // ch1 held 60 cycles: long pulse 32 cycles after press
        add(1, 2'b01, 10, 2'b10, 2'b10, 2'b00, 2'b00, 1, 0, 0);
        add(1, 2'b01, 31, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b01, 1, 2'b10, 2'b00, 2'b00, lng1, 0, 0, nl1);
        add(1, 2'b01, 18, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 6, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 0);
        // 30-cycle hold: no long pulse
        add(1, 2'b01, 30, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        add(1, 2'b11, 6, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 0);
        // simultaneous press and release on both channels
        add(1, 2'b00, 10, 2'b11, 2'b11, 2'b00, 2'b00, 2, 0, 0);
        add(1, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 6, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2, 0);
        // reset while held: silent abort, re-press 10 cycles after reset
        add(1, 2'b10, 12, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        add(0, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b10, 9, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        add(1, 2'b11, 6, 2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 0);

        cnt_p = 0; cnt_r = 0; cnt_l = 0;
        foreach (vecs[k]) begin
            cnt_p = 0; cnt_r = 0; cnt_l = 0;
            repeat (vecs[k].cyc) tick(vecs[k].rst, vecs[k].b);
            check($sformatf("v%0d_boton_out", k), 32'(boton_out), 32'(vecs[k].out));
            check($sformatf("v%0d_press", k), 32'(press_pulse), 32'(vecs[k].prs));
            check($sformatf("v%0d_release", k), 32'(release_pulse), 32'(vecs[k].rel));
            check($sformatf("v%0d_long", k), 32'(long_pulse), 32'(vecs[k].lng));
            check($sformatf("v%0d_n_press", k), 32'(cnt_p), 32'(vecs[k].np));
            check($sformatf("v%0d_n_release", k), 32'(cnt_r), 32'(vecs[k].nr));
            check($sformatf("v%0d_n_long", k), 32'(cnt_l), 32'(vecs[k].nl));
        end

        // Measured latencies on ch0: press, long press, release
        lat = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            tick(1, 2'b10);
            lat++;
            found = press_pulse[0];
        end
        check("press_latency", 32'(lat), 32'd10);

        lat = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            tick(1, 2'b10);
            lat++;
            found = long_pulse[0];
        end
        if (LP) check("long_latency", 32'(lat), 32'd32);
        else    check("long_absent", 32'(found), 32'd0);

        lat = 0;
        found = 1'b0;
        while (!found && lat < 20) begin
            tick(1, 2'b11);
            lat++;
            found = release_pulse[0];
        end
        check("release_latency", 32'(lat), 32'd6);
        check("release_level", 32'(boton_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
